// File: rtl/udp_hdr_gen.sv
// Writes a 42-byte Ethernet/IPv4/UDP header into BRAM bytes 0..41.
// Optional `UDP_HDR_SEQ_EN adds an incrementing IPv4 identification.
module udp_hdr_gen #(
  parameter logic [47:0] MAC_DST     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] MAC_SRC     = 48'h020000000001,
  parameter logic [31:0] IP_SRC      = 32'h0A000001,
  parameter logic [31:0] IP_DST      = 32'h0A000002,
  parameter logic [15:0] UDP_SPORT   = 16'd5000,
  parameter logic [15:0] UDP_DPORT   = 16'd5000,
  parameter int          PAYLOAD_LEN = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] seq
);

  typedef enum logic [2:0] {
    IDLE, SUM, FOLD, WRITE, DONE
  } state_t;

  localparam logic [15:0] TOT_LEN = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN = 16'(8 + PAYLOAD_LEN);

  state_t       state;
  logic [16:0]  acc;
  logic [15:0]  csum;
  logic [3:0]   idx;
  logic [15:0]  id;
  logic [15:0]  words [10];
  logic [41:0][7:0] hdr;
  logic [16:0]  f1;
  logic [15:0]  fold;
  logic [5:0]   nxt;
  logic [5:0]   bi;

`ifdef UDP_HDR_SEQ_EN
  logic [15:0] seq_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_cnt <= '0;
      id      <= '0;
    end else begin
      if (state == IDLE && start)
        id <= seq_cnt;
      if (state == DONE)
        seq_cnt <= seq_cnt + 16'd1;
    end
  end
`else
  assign id = '0;
`endif

  assign seq = id;

  // checksum word is summed as zero
  assign words = '{
    16'h4500, TOT_LEN, id, 16'h4000,
    16'h4011, 16'h0000,
    IP_SRC[31:16], IP_SRC[15:0],
    IP_DST[31:16], IP_DST[15:0]
  };

  assign hdr = {
    MAC_DST, MAC_SRC, 16'h0800,
    16'h4500, TOT_LEN, id,
    16'h4000, 16'h4011, csum,
    IP_SRC, IP_DST,
    UDP_SPORT, UDP_DPORT,
    UDP_LEN, 16'h0000
  };

  assign f1   = {1'b0, acc[15:0]} + {16'b0, acc[16]};
  assign fold = f1[15:0] + {15'b0, f1[16]};

  assign nxt = (state == FOLD) ? 6'd0
                               : wr_addr[5:0] + 6'd1;
  assign bi  = 6'd41 - nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      acc     <= '0;
      csum    <= '0;
      idx     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SUM;
            busy  <= 1'b1;
            acc   <= '0;
            idx   <= '0;
          end
        end
        SUM: begin
          // carry of previous add folds back in
          acc <= {1'b0, acc[15:0]}
               + {16'b0, acc[16]}
               + {1'b0, words[idx]};
          if (idx == 4'd9)
            state <= FOLD;
          else
            idx <= idx + 4'd1;
        end
        FOLD: begin
          csum    <= ~fold;
          state   <= WRITE;
          wr_en   <= 1'b1;
          wr_addr <= {4'b0, nxt};
          wr_data <= hdr[bi];
        end
        WRITE: begin
          if (wr_addr == 10'd41) begin
            state <= DONE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_addr <= {4'b0, nxt};
            wr_data <= hdr[bi];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_hdr_gen.sv
// Bench for udp_hdr_gen: default and 1024-byte payload instances
// driven in lockstep and compared against a byte-level header model.
module tb_udp_hdr_gen;

  localparam logic [47:0] B_MD = 48'h001122334455;
  localparam logic [47:0] B_MS = 48'h66778899AABB;
  localparam logic [31:0] B_IS = 32'hC0A80164;
  localparam logic [31:0] B_ID = 32'hC0A801C8;
  localparam logic [15:0] B_SP = 16'd1234;
  localparam logic [15:0] B_DP = 16'd80;

  typedef logic [7:0] hdr_t [42];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  busy, done, wr_en;
  logic [9:0]  wr_addr [2];
  logic [7:0]  wr_data [2];
  logic [15:0] seq [2];

  int checks = 0;
  int failures = 0;
  int exp_n = 0;
  int cyc = 0;

  int nwr [2] = '{0, 0};
  int ndone [2] = '{0, 0};
  int nbusy [2] = '{0, 0};
  int nbad [2] = '{0, 0};
  int c_a0 [2] = '{0, 0};
  int c_a41 [2] = '{0, 0};
  int c_done [2] = '{0, 0};
  logic [7:0] mem [2][42];

  always #5 clk = ~clk;

  udp_hdr_gen u_def (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[0]), .done(done[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .seq(seq[0])
  );

  udp_hdr_gen #(
    .MAC_DST(B_MD), .MAC_SRC(B_MS),
    .IP_SRC(B_IS), .IP_DST(B_ID),
    .UDP_SPORT(B_SP), .UDP_DPORT(B_DP),
    .PAYLOAD_LEN(1024)
  ) u_big (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[1]), .done(done[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .seq(seq[1])
  );

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (wr_en[u]) begin
        nwr[u] <= nwr[u] + 1;
        if (wr_addr[u] > 10'd41)
          nbad[u] <= nbad[u] + 1;
        else
          mem[u][int'(wr_addr[u])] <= wr_data[u];
        if (wr_addr[u] == 10'd0) c_a0[u] <= cyc;
        if (wr_addr[u] == 10'd41) c_a41[u] <= cyc;
      end
      if (done[u]) begin
        ndone[u] <= ndone[u] + 1;
        c_done[u] <= cyc;
      end
      if (busy[u]) nbusy[u] <= nbusy[u] + 1;
    end
    cyc <= cyc + 1;
  end

  function automatic hdr_t make_hdr(
    input logic [47:0] md, input logic [47:0] ms,
    input logic [31:0] ips, input logic [31:0] ipd,
    input logic [15:0] sp, input logic [15:0] dp,
    input int plen, input logic [15:0] idn);
    logic [7:0]  q [$];
    logic [15:0] w [10];
    logic [15:0] tl, ul, ck;
    int s;
    hdr_t h;
    tl = 16'(28 + plen);
    ul = 16'(8 + plen);
    w = '{16'h4500, tl, idn, 16'h4000, 16'h4011, 16'h0,
          ips[31:16], ips[15:0], ipd[31:16], ipd[15:0]};
    s = 0;
    foreach (w[i]) s += int'(w[i]);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    ck = ~16'(s);
    for (int b = 5; b >= 0; b--) q.push_back(md[b*8 +: 8]);
    for (int b = 5; b >= 0; b--) q.push_back(ms[b*8 +: 8]);
    q.push_back(8'h08); q.push_back(8'h00);
    q.push_back(8'h45); q.push_back(8'h00);
    q.push_back(tl[15:8]); q.push_back(tl[7:0]);
    q.push_back(idn[15:8]); q.push_back(idn[7:0]);
    q.push_back(8'h40); q.push_back(8'h00);
    q.push_back(8'h40); q.push_back(8'h11);
    q.push_back(ck[15:8]); q.push_back(ck[7:0]);
    for (int b = 3; b >= 0; b--) q.push_back(ips[b*8 +: 8]);
    for (int b = 3; b >= 0; b--) q.push_back(ipd[b*8 +: 8]);
    q.push_back(sp[15:8]); q.push_back(sp[7:0]);
    q.push_back(dp[15:8]); q.push_back(dp[7:0]);
    q.push_back(ul[15:8]); q.push_back(ul[7:0]);
    q.push_back(8'h00); q.push_back(8'h00);
    for (int i = 0; i < 42; i++) h[i] = q[i];
    return h;
  endfunction

  function automatic hdr_t ref_hdr(input int u, input logic [15:0] idn);
    if (u == 0)
      return make_hdr(48'hFFFFFFFFFFFF, 48'h020000000001,
                      32'h0A000001, 32'h0A000002,
                      16'd5000, 16'd5000, 512, idn);
    return make_hdr(B_MD, B_MS, B_IS, B_ID, B_SP, B_DP, 1024, idn);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_busy"}, 32'(busy[u]), 32'd0);
      chk({tag, "_done"}, 32'(done[u]), 32'd0);
      chk({tag, "_wren"}, 32'(wr_en[u]), 32'd0);
      chk({tag, "_addr"}, 32'(wr_addr[u]), 32'd0);
      chk({tag, "_data"}, 32'(wr_data[u]), 32'd0);
      chk({tag, "_seq"}, 32'(seq[u]), 32'd0);
    end
  endtask

  task automatic cyc_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit glitch);
    int k, r;
    int w0 [2], d0 [2], b0 [2];
    logic [15:0] eid;
    hdr_t h;
    repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef UDP_HDR_SEQ_EN
    eid = 16'(exp_n);
`else
    eid = 16'h0000;
`endif
    r = int'($urandom_range(1, 53));
    for (int u = 0; u < 2; u++) begin
      w0[u] = nwr[u]; d0[u] = ndone[u]; b0[u] = nbusy[u];
    end
    start = 1'b1;
    @(posedge clk);
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      start = glitch && (i == 5 || i == 30 || i == 54 || i == r);
      cyc_step();
    end
    start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      h = ref_hdr(u, eid);
      chk("n_writes", 32'(nwr[u] - w0[u]), 32'd42);
      chk("n_done", 32'(ndone[u] - d0[u]), 32'd1);
      chk("n_busy", 32'(nbusy[u] - b0[u]), 32'd53);
      chk("t_first_wr", 32'(c_a0[u] - k), 32'd12);
      chk("t_last_wr", 32'(c_a41[u] - k), 32'd53);
      chk("t_done", 32'(c_done[u] - k), 32'd54);
      chk("bad_addr", 32'(nbad[u]), 32'd0);
      chk("seq", 32'(seq[u]), 32'(eid));
      for (int i = 0; i < 42; i++)
        chk($sformatf("u%0d_byte%0d", u, i),
            32'(mem[u][i]), 32'(h[i]));
    end
    if (eid == 16'h0000)
      chk("csum_default", {16'h0, mem[0][24], mem[0][25]},
          32'h24CF);
    if (eid == 16'h0001)
      chk("csum_default_id1", {16'h0, mem[0][24], mem[0][25]},
          32'h24CE);
    chk("big_tot_len", {16'h0, mem[1][16], mem[1][17]}, 32'h041C);
    chk("big_udp_len", {16'h0, mem[1][38], mem[1][39]}, 32'h0408);
    exp_n++;
  endtask

  initial begin
    int w0, d0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    exp_n = 0;

    send(1'b0);
    send(1'b1);
    send(1'b0);

    // abort in the middle of the byte stream
    w0 = nwr[0]; d0 = ndone[0];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) cyc_step();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("abort");
    repeat (60) cyc_step();
    chk("abort_writes", 32'(nwr[0] - w0), 32'd9);
    chk("abort_done", 32'(ndone[0] - d0), 32'd0);
    chk("abort_seq", 32'(seq[0]), 32'd0);
    exp_n = 0;
    send(1'b0);

    // reset beats start in the same cycle
    w0 = nwr[0];
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk_idle("rst_vs_start");
    repeat (60) cyc_step();
    chk("rst_vs_start_wr", 32'(nwr[0] - w0), 32'd0);
    exp_n = 0;

    for (int n = 0; n < 4; n++)
      send(1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
